mips_trace_buffer: RTL and testbench
====================================

# mips_trace_buffer

- Synthesizable on-chip trace unit for the single-cycle MIPS core; it replaces per-cycle printing with a hardware capture path.
- Snoops the core's commit-side signals (PC, register write, memory write) into a parametrised circular buffer, timestamped by a cycle counter.
- Drains the captured records oldest-first over a valid/ready port.
- Sits beside the `mips` top level, fed from the same nets the core already exposes.

## Interface
Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, register/memory data width
- DEPTH, 16, trace entries; power of two, ≥2
- CYC_W, 16, timestamp width
- STOP_CYCLES, 100, auto-stop after this many capture cycles; 0 = no limit

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  pulse: arm and begin capture (honoured in IDLE only)
- stop  in  1  pulse: end capture (honoured in CAPTURE only)
- filt_mode  in  1  0 = record every cycle, 1 = record only cycles with reg_write or mem_write
- pc  in  ADDR_W  core PC of the committing instruction
- reg_write  in  1  core register-file write enable
- wr_reg  in  5  destination register
- wr_data  in  DATA_W  register write data
- mem_write  in  1  core data-memory write enable
- busy  out  1  high in CAPTURE or DRAIN
- overflow  out  1  sticky: an entry was overwritten during the current capture
- count  out  $clog2(DEPTH)+1  valid entries held
- rd_valid  out  1  record available (DRAIN and count>0)
- rd_ready  in  1  consumer accepts the record
- rd_cycle  out  CYC_W  timestamp of the record
- rd_pc  out  ADDR_W  PC of the record
- rd_flags  out  2  {mem_write, reg_write} of the record
- rd_reg  out  5  wr_reg of the record
- rd_data  out  DATA_W  wr_data of the record
- done  out  1  one-cycle pulse when the last record is accepted

## Operation
- States:
  - IDLE: reset state; start → CAPTURE.
  - CAPTURE:
    - Timestamp counter increments every cycle, starting at 0 on the first CAPTURE cycle; wraps modulo 2^CYC_W.
    - Records are written when filter-qualified.
    - Exits to DRAIN on stop, or on the cycle whose timestamp equals STOP_CYCLES-1 (when STOP_CYCLES≠0).
  - DRAIN: records are presented oldest-first; after the accept that empties the buffer → IDLE, with done asserted that same cycle.
    - Entering DRAIN with count=0 → IDLE next cycle, with done pulsed.
- Entering CAPTURE clears wr_ptr, rd_ptr, count, overflow and the timestamp.
- Record = {timestamp, pc, mem_write, reg_write, wr_reg, wr_data}. A cycle qualifies when filt_mode=0, or when reg_write|mem_write=1.
- Full buffer on a qualifying write: the new record overwrites the oldest; rd_ptr and wr_ptr both advance; count stays DEPTH; overflow is set.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count saturates at DEPTH.
- stop on the same cycle as a qualifying write: the record is written, then the FSM moves to DRAIN.
- Ignored inputs:
  - start outside IDLE.
  - stop outside CAPTURE.
  - rd_ready outside DRAIN.
- Reset asserted in any state, mid-capture or mid-drain: next edge returns to IDLE, count=0, overflow=0, all pointers 0; buffer contents are don't-care.

## Timing
- Reset values:
  - busy=0, overflow=0, count=0, rd_valid=0, done=0.
  - rd_* outputs are don't-care while rd_valid=0; drive them from the entry at rd_ptr.
- Write latency: a qualifying cycle n is counted in count at cycle n+1.
- rd_* is combinational from the entry at rd_ptr. A transfer occurs on a rising edge with rd_valid&rd_ready; the next record appears in the following cycle, giving 1 record/cycle under continuous ready.
- rd_valid stays high and rd_* stays stable until accepted; rd_valid does not depend on rd_ready.
- Auto-stop: with STOP_CYCLES=N, exactly N capture cycles (timestamps 0..N-1) are eligible for recording.
- done is registered: high for exactly one cycle, coincident with the final accepted transfer.

## Structure
- Package mips_dbg_pkg holds:
  - trace state enum (IDLE, CAPTURE, DRAIN);
  - flag bit positions (FLAG_REG=0, FLAG_MEM=1);
  - a packed trace-record struct parameterised through localparams derived from ADDR_W/DATA_W/CYC_W.
- Sub-module trace_ram: DEPTH × record-width, one synchronous write port, one asynchronous read port, no reset.
- The top level holds the FSM, pointers, count, timestamp and filter.

## Test plan
- Baseline: DEPTH=16, STOP_CYCLES=8, filt_mode=0, start, pc stepping 0x0,0x4,… → DRAIN with count=8; rd_ready=1 yields timestamps 0..7 and pc 0x00..0x1C in order; done on the 8th transfer.
- Filter: filt_mode=1, reg_write high only at timestamps 2 and 5 (wr_reg=8, wr_data=0xDEADBEEF at 5), stop at timestamp 6 → exactly 2 records: {2,…} then {5,flags=01,reg 8,0xDEADBEEF}.
- Wrap/overflow: DEPTH=4, STOP_CYCLES=10, filt_mode=0 → count=4, overflow=1, drained timestamps 6,7,8,9.
- Backpressure: in DRAIN toggle rd_ready 1,0,0,1 → rd_valid held, record unchanged across the stalled cycles, no loss or duplication.
- Corner cases:
  - stop on the same cycle as a write → that record is present.
  - start pulsed during DRAIN → ignored.
  - reset low mid-capture → next cycle busy=0, count=0, overflow=0.
- STOP_CYCLES=0 → capture runs until stop; after 300 cycles the timestamp has wrapped past 2^CYC_W only if CYC_W<9; with CYC_W=16, drained timestamps are 284..299 for DEPTH=16.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS debug/trace path: FSM states, record flag bits and the default record layout.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } trace_state_t;

    localparam int FLAG_REG = 0;
    localparam int FLAG_MEM = 1;

    localparam int TR_ADDR_W = 32;
    localparam int TR_DATA_W = 32;
    localparam int TR_CYC_W  = 16;
    localparam int TR_REC_W  = TR_CYC_W + TR_ADDR_W + 2 + 5 + TR_DATA_W;

    // Record layout for the default core widths; the top re-declares it from its own parameters.
    typedef struct packed {
        logic [TR_CYC_W-1:0]  cycle;
        logic [TR_ADDR_W-1:0] pc;
        logic [1:0]           flags;
        logic [4:0]           reg_idx;
        logic [TR_DATA_W-1:0] data;
    } trace_rec_t;

endpackage

// File: rtl/mips_trace_buffer_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Commit-side trace capture for the single-cycle MIPS core: timestamps and filters core commits into a
// circular buffer (oldest overwritten when full) and drains it oldest-first over a valid/ready port.
module mips_trace_buffer
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYC_W       = 16,
    parameter int STOP_CYCLES = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     filt_mode,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     reg_write,
    input  logic [4:0]               wr_reg,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     mem_write,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [1:0]               rd_flags,
    output logic [4:0]               rd_reg,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     done
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int REC_W = CYC_W + ADDR_W + 2 + 5 + DATA_W;

    typedef struct packed {
        logic [CYC_W-1:0]  cycle;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        flags;
        logic [4:0]        reg_idx;
        logic [DATA_W-1:0] data;
    } rec_t;

    trace_state_t      state, state_nxt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CYC_W-1:0]  ts;
    logic              qualify, auto_stop, full, xfer;
    rec_t              wr_rec, rd_rec;

    assign qualify   = (state == CAPTURE) && (!filt_mode || reg_write || mem_write);
    assign auto_stop = (STOP_CYCLES != 0) && (ts == CYC_W'(STOP_CYCLES - 1));
    assign full      = (count == CW'(DEPTH));
    assign rd_valid  = (state == DRAIN) && (count != '0);
    assign xfer      = rd_valid && rd_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        wr_rec                 = '0;
        wr_rec.cycle           = ts;
        wr_rec.pc              = pc;
        wr_rec.flags[FLAG_REG] = reg_write;
        wr_rec.flags[FLAG_MEM] = mem_write;
        wr_rec.reg_idx         = wr_reg;
        wr_rec.data            = wr_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: if (stop || auto_stop) state_nxt = DRAIN;
            DRAIN:   if (count == '0 || (xfer && count == CW'(1))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ts       <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && (state_nxt == IDLE);
            if (state == IDLE && start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
                ts       <= '0;
            end else if (state == CAPTURE) begin
                ts <= ts + 1'b1;
                if (qualify) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    // Full: drop the oldest entry so the buffer keeps the most recent DEPTH records.
                    if (full) begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            end else if (xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (qualify),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    assign rd_cycle = rd_rec.cycle;
    assign rd_pc    = rd_rec.pc;
    assign rd_flags = rd_rec.flags;
    assign rd_reg   = rd_rec.reg_idx;
    assign rd_data  = rd_rec.data;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: three instances cover baseline/filter (16 deep, stop 8),
// wrap/overflow (4 deep, stop 10) and unlimited capture (16 deep, no stop limit).
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        filt_mode;
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        mem_write;

    logic        a_start, a_stop, a_rdy, a_busy, a_ovf, a_vld, a_done;
    logic [4:0]  a_cnt;
    logic [15:0] a_cyc;
    logic [31:0] a_pc, a_dat;
    logic [1:0]  a_flg;
    logic [4:0]  a_reg;

    logic        b_start, b_stop, b_rdy, b_busy, b_ovf, b_vld, b_done;
    logic [2:0]  b_cnt;
    logic [15:0] b_cyc;
    logic [31:0] b_pc, b_dat;
    logic [1:0]  b_flg;
    logic [4:0]  b_reg;

    logic        c_start, c_stop, c_rdy, c_busy, c_ovf, c_vld, c_done;
    logic [4:0]  c_cnt;
    logic [15:0] c_cyc;
    logic [31:0] c_pc, c_dat;
    logic [1:0]  c_flg;
    logic [4:0]  c_reg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_trace_buffer #(.DEPTH(16), .STOP_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .filt_mode(filt_mode),
        .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data), .mem_write(mem_write),
        .busy(a_busy), .overflow(a_ovf), .count(a_cnt), .rd_valid(a_vld), .rd_ready(a_rdy),
        .rd_cycle(a_cyc), .rd_pc(a_pc), .rd_flags(a_flg), .rd_reg(a_reg), .rd_data(a_dat),
        .done(a_done));

    mips_trace_buffer #(.DEPTH(4), .STOP_CYCLES(10)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .filt_mode(filt_mode),
        .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data), .mem_write(mem_write),
        .busy(b_busy), .overflow(b_ovf), .count(b_cnt), .rd_valid(b_vld), .rd_ready(b_rdy),
        .rd_cycle(b_cyc), .rd_pc(b_pc), .rd_flags(b_flg), .rd_reg(b_reg), .rd_data(b_dat),
        .done(b_done));

    mips_trace_buffer #(.DEPTH(16), .STOP_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .stop(c_stop), .filt_mode(filt_mode),
        .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data), .mem_write(mem_write),
        .busy(c_busy), .overflow(c_ovf), .count(c_cnt), .rd_valid(c_vld), .rd_ready(c_rdy),
        .rd_cycle(c_cyc), .rd_pc(c_pc), .rd_flags(c_flg), .rd_reg(c_reg), .rd_data(c_dat),
        .done(c_done));

    // Outputs are sampled, and inputs changed, 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({a_busy, a_ovf, a_vld, a_done} !== 4'b0000 || a_cnt !== 5'd0) begin
            bad++;
            $display("FAIL reset busy/ovf/vld/done=%b%b%b%b count=%0d expected 0000 count=0",
                     a_busy, a_ovf, a_vld, a_done, a_cnt);
        end
        total++;
        if (b_busy !== 1'b0 || b_cnt !== 3'd0 || c_busy !== 1'b0 || c_cnt !== 5'd0) begin
            bad++;
            $display("FAIL reset_bc b_busy=%b b_cnt=%0d c_busy=%b c_cnt=%0d expected all 0",
                     b_busy, b_cnt, c_busy, c_cnt);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_baseline();
        filt_mode = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pc = 32'(4 * k);
            tick();
        end
        total++;
        if (a_busy !== 1'b1 || a_vld !== 1'b1 || a_cnt !== 5'd8 || a_ovf !== 1'b0) begin
            bad++;
            $display("FAIL base_autostop busy=%b vld=%b count=%0d ovf=%b expected 1 1 8 0",
                     a_busy, a_vld, a_cnt, a_ovf);
        end
        a_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (a_cyc !== 16'(i) || a_pc !== 32'(4 * i) || a_vld !== 1'b1 || a_done !== 1'b0) begin
                bad++;
                $display("FAIL base_rec%0d ts=%0d pc=%h vld=%b done=%b expected ts=%0d pc=%h vld=1 done=0",
                         i, a_cyc, a_pc, a_vld, a_done, i, 4 * i);
            end
            tick();
        end
        a_rdy = 1'b0;
        total++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_vld !== 1'b0 || a_cnt !== 5'd0) begin
            bad++;
            $display("FAIL base_done done=%b busy=%b vld=%b count=%0d expected 1 0 0 0",
                     a_done, a_busy, a_vld, a_cnt);
        end
        tick();
        total++;
        if (a_done !== 1'b0) begin
            bad++;
            $display("FAIL base_done_pulse done=%b expected 0", a_done);
        end
    endtask

    // Filtered capture; the drain also exercises backpressure with rd_ready 1,0,0,1.
    task automatic test_filter_backpressure();
        filt_mode = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            pc        = 32'h100 + 32'(4 * t);
            reg_write = (t == 2 || t == 5);
            wr_reg    = (t == 5) ? 5'd8 : 5'd3;
            wr_data   = (t == 5) ? 32'hDEADBEEF : 32'h11111111;
            a_stop    = (t == 6);
            tick();
        end
        a_stop = 1'b0;
        reg_write = 1'b0;
        total++;
        if (a_cnt !== 5'd2 || a_vld !== 1'b1) begin
            bad++;
            $display("FAIL filt_count count=%0d vld=%b expected 2 1", a_cnt, a_vld);
        end
        total++;
        if (a_cyc !== 16'd2 || a_pc !== 32'h108 || a_flg !== 2'b01 || a_reg !== 5'd3 ||
            a_dat !== 32'h11111111) begin
            bad++;
            $display("FAIL filt_rec0 ts=%0d pc=%h flg=%b reg=%0d dat=%h expected 2 108 01 3 11111111",
                     a_cyc, a_pc, a_flg, a_reg, a_dat);
        end
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            total++;
            if (a_vld !== 1'b1 || a_cyc !== 16'd5 || a_pc !== 32'h114 || a_flg !== 2'b01 ||
                a_reg !== 5'd8 || a_dat !== 32'hDEADBEEF || a_cnt !== 5'd1) begin
                bad++;
                $display("FAIL filt_rec1_stall%0d vld=%b ts=%0d pc=%h flg=%b reg=%0d dat=%h cnt=%0d expected 1 5 114 01 8 deadbeef 1",
                         s, a_vld, a_cyc, a_pc, a_flg, a_reg, a_dat, a_cnt);
            end
            if (s < 2) tick();
        end
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        total++;
        if (a_done !== 1'b1 || a_cnt !== 5'd0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL filt_done done=%b count=%0d busy=%b expected 1 0 0", a_done, a_cnt, a_busy);
        end
        filt_mode = 1'b0;
    endtask

    // Stop coincides with a write; a start pulse during DRAIN must not re-arm.
    task automatic test_stop_write_start_in_drain();
        filt_mode = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            pc = 32'h200 + 32'(4 * t);
            a_stop = (t == 2);
            tick();
        end
        a_stop = 1'b0;
        total++;
        if (a_cnt !== 5'd3 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL stopwr_count count=%0d busy=%b expected 3 1", a_cnt, a_busy);
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        total++;
        if (a_cnt !== 5'd3 || a_vld !== 1'b1 || a_cyc !== 16'd0) begin
            bad++;
            $display("FAIL start_in_drain count=%0d vld=%b ts=%0d expected 3 1 0", a_cnt, a_vld, a_cyc);
        end
        a_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (a_cyc !== 16'(i) || a_pc !== 32'h200 + 32'(4 * i)) begin
                bad++;
                $display("FAIL stopwr_rec%0d ts=%0d pc=%h expected %0d %h", i, a_cyc, a_pc, i, 32'h200 + 4 * i);
            end
            tick();
        end
        a_rdy = 1'b0;
        total++;
        if (a_done !== 1'b1) begin
            bad++;
            $display("FAIL stopwr_done done=%b expected 1", a_done);
        end
    endtask

    task automatic test_empty_drain();
        filt_mode = 1'b1;
        reg_write = 1'b0;
        mem_write = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        total++;
        if (a_busy !== 1'b1 || a_vld !== 1'b0 || a_cnt !== 5'd0 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL empty_drain busy=%b vld=%b count=%0d done=%b expected 1 0 0 0",
                     a_busy, a_vld, a_cnt, a_done);
        end
        tick();
        total++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_done done=%b busy=%b expected 1 0", a_done, a_busy);
        end
        filt_mode = 1'b0;
    endtask

    task automatic test_wrap_overflow();
        filt_mode = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pc = 32'h300 + 32'(4 * k);
            tick();
        end
        total++;
        if (b_cnt !== 3'd4 || b_ovf !== 1'b1 || b_vld !== 1'b1) begin
            bad++;
            $display("FAIL wrap_state count=%0d ovf=%b vld=%b expected 4 1 1", b_cnt, b_ovf, b_vld);
        end
        b_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (b_cyc !== 16'(6 + i) || b_pc !== 32'h300 + 32'(4 * (6 + i))) begin
                bad++;
                $display("FAIL wrap_rec%0d ts=%0d pc=%h expected %0d %h", i, b_cyc, b_pc, 6 + i,
                         32'h300 + 4 * (6 + i));
            end
            tick();
        end
        b_rdy = 1'b0;
        total++;
        if (b_done !== 1'b1 || b_cnt !== 3'd0) begin
            bad++;
            $display("FAIL wrap_done done=%b count=%0d expected 1 0", b_done, b_cnt);
        end
    endtask

    task automatic test_no_limit();
        filt_mode = 1'b0;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            pc = 32'(4 * k);
            c_stop = (k == 299);
            tick();
        end
        c_stop = 1'b0;
        total++;
        if (c_cnt !== 5'd16 || c_ovf !== 1'b1 || c_busy !== 1'b1) begin
            bad++;
            $display("FAIL nolimit_state count=%0d ovf=%b busy=%b expected 16 1 1", c_cnt, c_ovf, c_busy);
        end
        c_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (c_cyc !== 16'(284 + i) || c_pc !== 32'(4 * (284 + i))) begin
                bad++;
                $display("FAIL nolimit_rec%0d ts=%0d pc=%h expected %0d %h", i, c_cyc, c_pc, 284 + i,
                         4 * (284 + i));
            end
            tick();
        end
        c_rdy = 1'b0;
        total++;
        if (c_done !== 1'b1) begin
            bad++;
            $display("FAIL nolimit_done done=%b expected 1", c_done);
        end
    endtask

    task automatic test_reset_mid_capture();
        filt_mode = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (b_ovf !== 1'b1 || b_cnt !== 3'd4 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL midcap_pre ovf=%b count=%0d busy=%b expected 1 4 1", b_ovf, b_cnt, b_busy);
        end
        reset = 1'b0;
        tick();
        total++;
        if (b_busy !== 1'b0 || b_cnt !== 3'd0 || b_ovf !== 1'b0 || b_vld !== 1'b0) begin
            bad++;
            $display("FAIL midcap_reset busy=%b count=%0d ovf=%b vld=%b expected 0 0 0 0",
                     b_busy, b_cnt, b_ovf, b_vld);
        end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        filt_mode = 1'b0;
        pc = '0;
        reg_write = 1'b0;
        wr_reg = '0;
        wr_data = '0;
        mem_write = 1'b0;
        {a_start, a_stop, a_rdy} = '0;
        {b_start, b_stop, b_rdy} = '0;
        {c_start, c_stop, c_rdy} = '0;
        #2;
        test_reset();
        test_baseline();
        test_filter_backpressure();
        test_stop_write_start_in_drain();
        test_empty_drain();
        test_wrap_overflow();
        test_no_limit();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
